mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive data grants allowed while a fetch request waits.
REQ-002 Parameter AW, default 32: address width. Parameter DW, default 32: data width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  fetch-port read request, held until i_ack.
REQ-006 i_addr  input  AW  fetch address, stable while i_req is high.
REQ-007 i_rdata  output  DW  fetch read data, valid when i_ack is high.
REQ-008 i_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data-port request, held until d_ack.
REQ-010 d_we  input  1  data-port write enable, stable while d_req is high.
REQ-011 d_addr  input  AW  data address. d_wdata  input  DW  write data.
REQ-012 d_rdata  output  DW  data read data, valid when d_ack is high. d_ack  output  1  one-cycle data completion pulse.
REQ-013 m_en  output  1  memory access active. m_we  output  1  memory write.
REQ-014 m_addr  output  AW  memory address. m_wdata  output  DW  memory write data.
REQ-015 m_rdata  input  DW  memory read data. m_ready  input  1  memory access complete this cycle.
REQ-016 stall_f  output  1  i_req & ~i_ack, to the hazard unit. stall_m  output  1  d_req & ~d_ack, to the hazard unit.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-018 IDLE: when any request is high, the arbiter SHALL latch the winner's address, write enable and write data into m_* registers and enter BUSY on the next edge.
REQ-019 Arbitration: data wins when both requests are high, except when starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-020 starve_cnt SHALL increment on a data grant with i_req high, and clear on any fetch grant or any grant with i_req low.
REQ-021 starve_cnt SHALL saturate at STARVE_MAX.
REQ-022 BUSY: m_en SHALL be high and all m_* outputs SHALL hold constant until m_ready is sampled high.
REQ-023 On m_ready in BUSY, the arbiter SHALL register m_rdata into the granted port's rdata and enter RESP.
REQ-024 A write access SHALL leave d_rdata unchanged.
REQ-025 RESP: the granted port's ack SHALL be high for exactly one cycle, m_en SHALL be low, and requests SHALL be ignored; the next state is IDLE.
REQ-026 Minimum access latency SHALL be 3 cycles (request to ack) when m_ready is high in the first BUSY cycle.
REQ-027 m_ready SHALL be ignored outside BUSY.
REQ-028 A request deasserted while BUSY (illegal) SHALL NOT abort the access; the ack is still issued.
REQ-029 i_ack and d_ack SHALL never be high in the same cycle.
REQ-030 rdata outputs SHALL hold their last value between acks.

Reset
REQ-031 While reset is low, the arbiter SHALL be in IDLE with starve_cnt = 0 and m_en, m_we, i_ack, d_ack = 0.
REQ-032 While reset is low, m_addr, m_wdata, i_rdata and d_rdata SHALL be 0.
REQ-033 Reset asserted mid-access SHALL abandon the access, and no ack SHALL be produced after release.
REQ-034 On the first edge after release, the arbiter SHALL evaluate requests normally from IDLE.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, RESP=2'b10), the grant-owner encoding (GNT_I, GNT_D) and the default STARVE_MAX.
REQ-036 The block SHALL be a single module with no sub-modules; the starvation counter and grant logic are inline.

Verification
REQ-037 Single fetch: i_req=1, i_addr=0x10, m_ready high in the first BUSY cycle, m_rdata=0xE3A0_0001 -> i_ack pulses 3 cycles after request with i_rdata=0xE3A0_0001; stall_f=1 for 2 cycles.
REQ-038 Contention: i_req and d_req both high in the same cycle, d_we=1, d_addr=0x80, d_wdata=0x55 -> data granted first (m_we=1, m_addr=0x80, m_wdata=0x55); fetch granted next; d_ack precedes i_ack.
REQ-039 Starvation: i_req held high, d_req re-asserted after every d_ack, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant, then starve_cnt=0.
REQ-040 Wait states: m_ready low for 5 BUSY cycles -> m_en, m_addr and m_wdata constant for 6 cycles; ack appears the cycle after m_ready is sampled.
REQ-041 Reset mid-access: reset low in the second BUSY cycle and released 2 cycles later, m_ready pulsed afterwards -> no ack, m_en=0, state IDLE.
REQ-042 Ack exclusivity: randomized req/m_ready traffic for 10,000 cycles -> assertion never fires for i_ack & d_ack, and m_* outputs never change while m_en is high before m_ready.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states, grant owner
// and default parameter values.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_t;

   localparam int unsigned STARVE_MAX_DEF = 4;
   localparam int unsigned AW_DEF         = 32;
   localparam int unsigned DW_DEF         = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, data port, arbiter and memory.
// slave = the arbiter's view, master = the surrounding pipeline and memory.
interface mem_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;

   logic          m_en;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ready;

   logic          stall_f;
   logic          stall_m;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
      output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata,
             stall_f, stall_m
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
      input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata,
             stall_f, stall_m
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, one access at
// a time. Data has priority, but fetch wins after STARVE_MAX back-to-back data grants.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
   parameter int unsigned AW         = AW_DEF,
   parameter int unsigned DW         = DW_DEF
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   localparam int unsigned    CW      = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(STARVE_MAX);

   state_t        r_state, w_state_nxt;
   gnt_t          r_gnt, w_gnt;
   logic [CW-1:0] r_starve_cnt, w_starve_nxt;
   logic          w_grant;
   logic          r_m_we;
   logic [AW-1:0] r_m_addr;
   logic [DW-1:0] r_m_wdata;
   logic [DW-1:0] r_i_rdata;
   logic [DW-1:0] r_d_rdata;
   logic          w_i_ack, w_d_ack;

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve_cnt;
      w_grant      = 1'b0;
      w_gnt        = (bus.i_req && (!bus.d_req || r_starve_cnt == CNT_MAX)) ? GNT_I : GNT_D;
      case (r_state)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               w_grant     = 1'b1;
               w_state_nxt = BUSY;
               if (w_gnt == GNT_D && bus.i_req)
                  w_starve_nxt = (r_starve_cnt == CNT_MAX) ? CNT_MAX : r_starve_cnt + 1'b1;
               else
                  w_starve_nxt = '0;
            end
         end
         BUSY:    if (bus.m_ready) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // Request inputs are only looked at in IDLE; m_* is frozen for the whole access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gnt     <= GNT_I;
         r_m_we    <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_grant) begin
            r_gnt     <= w_gnt;
            r_m_we    <= (w_gnt == GNT_D) && bus.d_we;
            r_m_addr  <= (w_gnt == GNT_I) ? bus.i_addr : bus.d_addr;
            r_m_wdata <= (w_gnt == GNT_D) ? bus.d_wdata : '0;
         end
         if (r_state == BUSY && bus.m_ready) begin
            if (r_gnt == GNT_I)
               r_i_rdata <= bus.m_rdata;
            else if (!r_m_we)
               r_d_rdata <= bus.m_rdata;
         end
      end
   end

   assign w_i_ack = (r_state == RESP) && (r_gnt == GNT_I);
   assign w_d_ack = (r_state == RESP) && (r_gnt == GNT_D);

   assign bus.i_ack   = w_i_ack;
   assign bus.d_ack   = w_d_ack;
   assign bus.i_rdata = r_i_rdata;
   assign bus.d_rdata = r_d_rdata;
   assign bus.m_en    = (r_state == BUSY);
   assign bus.m_we    = r_m_we;
   assign bus.m_addr  = r_m_addr;
   assign bus.m_wdata = r_m_wdata;
   assign bus.stall_f = bus.i_req & ~w_i_ack;
   assign bus.stall_m = bus.d_req & ~w_d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by random
// request and wait-state traffic, checked against a behavioural model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SMAX = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   mem_arbiter #(.STARVE_MAX(SMAX), .AW(AW), .DW(DW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory contents as a fixed function of address; address 0x10 holds 0xE3A0_0001.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return ((a ^ 32'h10) * 32'h9E37_79B1) ^ 32'hE3A0_0001;
   endfunction

   assign bus.m_rdata = mem_f(bus.m_addr);

   // Memory responder: fixed wait states or random readiness.
   int wait_n      = 0;
   bit rand_ready  = 1'b0;
   int busy_cycles = 0;
   initial bus.m_ready = 1'b0;
   always @(posedge clk) begin
      #1;
      if (bus.m_en) busy_cycles++;
      else          busy_cycles = 0;
      if (rand_ready) bus.m_ready = ($urandom_range(0, 2) == 0);
      else            bus.m_ready = bus.m_en ? (busy_cycles > wait_n) : 1'b1;
   end

   // Scoreboard: expected read data per port, pushed at issue time.
   logic [31:0] fq[$];
   logic [31:0] dq[$];
   logic [31:0] last_d_read = '0;

   task automatic issue_f(input logic [31:0] a);
      bus.i_req  = 1'b1;
      bus.i_addr = a;
      fq.push_back(mem_f(a));
   endtask

   task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = a;
      bus.d_wdata = wd;
      if (!we) last_d_read = mem_f(a);
      dq.push_back(last_d_read);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input bit dport, input int max, output int lat, output int st);
      lat = 0;
      st  = 0;
      while (!(dport ? bus.d_ack : bus.i_ack)) begin
         if (dport ? bus.stall_m : bus.stall_f) st++;
         if (lat >= max) begin
            check("ack_timeout", 1, 0);
            return;
         end
         tick();
         lat++;
      end
   endtask

   task automatic wait_any(input int max);
      int n = 0;
      while (!(bus.i_ack || bus.d_ack)) begin
         if (n >= max) begin
            check("any_ack_timeout", 1, 0);
            return;
         end
         tick();
         n++;
      end
   endtask

   // Monitor: pops expectations on acks, predicts grant owner and checks m_* hold.
   int          model_starve = 0;
   logic        p_i_req = 0, p_d_req = 0, p_m_en = 0, p_m_ready = 0, p_we = 0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   bit          exp_f;

   always @(negedge clk) begin
      if (!reset) begin
         model_starve = 0;
         p_m_en       = 1'b0;
         p_i_req      = 1'b0;
         p_d_req      = 1'b0;
      end else begin
         check("ack_exclusive", bus.i_ack & bus.d_ack, 0);
         if (bus.i_ack) begin
            if (fq.size() == 0) check("i_ack_unexpected", 1, 0);
            else                check("i_rdata", bus.i_rdata, fq.pop_front());
         end
         if (bus.d_ack) begin
            if (dq.size() == 0) check("d_ack_unexpected", 1, 0);
            else                check("d_rdata", bus.d_rdata, dq.pop_front());
         end
         if (bus.m_en && p_m_en && !p_m_ready)
            check("m_hold", {bus.m_we, bus.m_addr, bus.m_wdata}, {p_we, p_addr, p_wdata});
         if (bus.m_en && !p_m_en) begin
            if (!p_i_req && !p_d_req) begin
               check("grant_without_req", 1, 0);
            end else begin
               exp_f = p_i_req && (!p_d_req || model_starve == SMAX);
               if (exp_f) begin
                  check("grant_fetch", {bus.m_we, bus.m_addr}, {1'b0, bus.i_addr});
               end else begin
                  check("grant_data", {bus.m_we, bus.m_addr}, {bus.d_we, bus.d_addr});
                  if (bus.d_we) check("grant_wdata", bus.m_wdata, bus.d_wdata);
               end
               model_starve = (!exp_f && p_i_req) ? ((model_starve < SMAX) ? model_starve + 1 : SMAX) : 0;
            end
         end
         p_i_req   = bus.i_req;
         p_d_req   = bus.d_req;
         p_m_en    = bus.m_en;
         p_m_ready = bus.m_ready;
         p_we      = bus.m_we;
         p_addr    = bus.m_addr;
         p_wdata   = bus.m_wdata;
      end
   end

   assert property (@(posedge clk) disable iff (!reset) !(bus.i_ack && bus.d_ack));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lat, st, n, en_cnt, last_en, ack_at;
      reset       = 1'b0;
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      repeat (2) tick();

      check("rst_state",   dut.r_state, IDLE);
      check("rst_starve",  dut.r_starve_cnt, 0);
      check("rst_outputs", {bus.m_en, bus.m_we, bus.i_ack, bus.d_ack}, 0);
      check("rst_data",    {bus.m_addr, bus.m_wdata, bus.i_rdata}, 0);
      check("rst_d_rdata", bus.d_rdata, 0);
      reset = 1'b1;
      tick();

      // Single fetch, zero wait states.
      issue_f(32'h10);
      #1;
      wait_ack(1'b0, 10, lat, st);
      check("fetch_latency", lat, 2);
      check("fetch_stall_cycles", st, 2);
      check("fetch_rdata_direct", bus.i_rdata, 32'hE3A0_0001);
      bus.i_req = 1'b0;
      tick();

      // Contention: data write wins, then fetch.
      issue_f(32'h20);
      issue_d(1'b1, 32'h80, 32'h55);
      wait_any(20);
      check("contention_first_is_data", {bus.d_ack, bus.i_ack}, 2'b10);
      bus.d_req = 1'b0;
      tick();
      wait_ack(1'b0, 20, lat, st);
      bus.i_req = 1'b0;
      tick();

      // Starvation: fetch held while data re-requests after each ack.
      issue_f(32'h40);
      issue_d(1'b0, 32'h100, 32'h0);
      n = 0;
      for (int k = 0; k < 12; k++) begin
         wait_any(20);
         if (bus.i_ack) break;
         n++;
         issue_d(1'b0, 32'h100 + 32'(n * 4), 32'h0);
         tick();
      end
      check("starve_data_grants", n, SMAX);
      check("starve_cnt_after_fetch", dut.r_starve_cnt, 0);
      bus.i_req = 1'b0;
      tick();
      wait_ack(1'b1, 20, lat, st);
      bus.d_req = 1'b0;
      tick();

      // Wait states: five cycles of m_ready low.
      wait_n = 5;
      issue_d(1'b1, 32'h44, 32'hCAFE);
      en_cnt  = 0;
      last_en = -1;
      ack_at  = -1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (bus.m_en) begin
            en_cnt++;
            last_en = c;
         end
         if (bus.d_ack) begin
            ack_at = c;
            break;
         end
      end
      check("ws_m_en_cycles", en_cnt, 6);
      check("ws_ack_after_ready", ack_at - last_en, 1);
      bus.d_req = 1'b0;
      tick();

      // Reset in the second BUSY cycle abandons the access.
      wait_n = 10;
      issue_f(32'h30);
      tick();
      tick();
      check("rst_mid_in_busy", bus.m_en, 1);
      reset       = 1'b0;
      bus.i_req   = 1'b0;
      fq.delete();
      dq.delete();
      last_d_read = '0;
      #1;
      check("rst_mid_outputs", {bus.m_en, bus.m_we, bus.i_ack, bus.d_ack}, 0);
      check("rst_mid_data", {bus.m_addr, bus.m_wdata, bus.i_rdata}, 0);
      check("rst_mid_d_rdata", bus.d_rdata, 0);
      check("rst_mid_state", dut.r_state, IDLE);
      tick();
      tick();
      reset  = 1'b1;
      wait_n = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("post_rst_quiet", {bus.m_en, bus.i_ack, bus.d_ack}, 0);
      end
      check("post_rst_state", dut.r_state, IDLE);

      // Random traffic with random wait states.
      rand_ready = 1'b1;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (bus.i_ack) begin
            if ($urandom_range(0, 1) == 1) issue_f(32'($urandom_range(0, 255) * 4));
            else                           bus.i_req = 1'b0;
         end else if (!bus.i_req && $urandom_range(0, 3) == 0) begin
            issue_f(32'($urandom_range(0, 255) * 4));
         end
         if (bus.d_ack) begin
            if ($urandom_range(0, 1) == 1)
               issue_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255) * 4), $urandom);
            else
               bus.d_req = 1'b0;
         end else if (!bus.d_req && $urandom_range(0, 3) == 0) begin
            issue_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255) * 4), $urandom);
         end
         tick();
      end
      for (int c = 0; c < 400 && (bus.i_req || bus.d_req); c++) begin
         if (bus.i_ack) bus.i_req = 1'b0;
         if (bus.d_ack) bus.d_req = 1'b0;
         tick();
      end
      check("drain_done", {bus.i_req, bus.d_req}, 0);
      tick();
      check("fq_empty", fq.size(), 0);
      check("dq_empty", dq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
